wb_arbiter: RTL and testbench

Writeback arbiter that owns the register file write port (rd_wren/rd_addr/rd_data) and merges single-cycle pipeline results with out-of-band load responses from the memory interface. It tracks issued loads in an in-order pending queue, resolves port contention with fixed ALU priority, and suppresses x0 writes. It reports source-register hazards to decode so that dependent instructions stall until load data is committed. It sits between execute/memory and the register file, on the write side of the register file's read/bypass ports.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_arbiter_if.sv | 33 +++
 rtl/wb_ld_fifo.sv | 44 ++++
 rtl/wb_arbiter.sv | 71 +++++++
 tb/tb_wb_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and defaults for the writeback arbiter.
package wb_pkg;
    localparam int XLEN = 32;
    localparam int LD_DEPTH = 4;
    typedef logic [$clog2(LD_DEPTH):0] pend_t;
    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: pipeline, load-queue, register-file and scoreboard signals of the writeback arbiter.
interface wb_arbiter_if #(parameter int DEPTH = wb_pkg::LD_DEPTH);
    import wb_pkg::*;
    logic                     alu_valid;
    logic [4:0]               alu_rd_addr;
    logic [XLEN-1:0]          alu_rd_data;
    logic                     ld_issue;
    logic [4:0]               ld_issue_rd;
    logic                     ld_issue_ready;
    logic                     ld_resp_valid;
    logic [XLEN-1:0]          ld_resp_data;
    logic                     ld_resp_ready;
    logic                     rd_wren;
    logic [4:0]               rd_addr;
    logic [XLEN-1:0]          rd_data;
    logic [4:0]               rs1_addr;
    logic [4:0]               rs2_addr;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic [$clog2(DEPTH):0]   ld_pending;
    modport master (
        output alu_valid, alu_rd_addr, alu_rd_data, ld_issue, ld_issue_rd,
               ld_resp_valid, ld_resp_data, rs1_addr, rs2_addr,
        input  ld_issue_ready, ld_resp_ready, rd_wren, rd_addr, rd_data,
               rs1_busy, rs2_busy, ld_pending
    );
    modport slave (
        input  alu_valid, alu_rd_addr, alu_rd_data, ld_issue, ld_issue_rd,
               ld_resp_valid, ld_resp_data, rs1_addr, rs2_addr,
        output ld_issue_ready, ld_resp_ready, rd_wren, rd_addr, rd_data,
               rs1_busy, rs2_busy, ld_pending
    );
endinterface

// File: rtl/wb_ld_fifo.sv
// wb_ld_fifo: in-order queue of pending load destinations with per-entry valid and address exposure.
module wb_ld_fifo #(parameter int DEPTH = 4) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [4:0]                  i_push_addr,
    input  logic                        i_pop,
    output logic [4:0]                  o_pop_addr,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [DEPTH-1:0]            o_vld,
    output logic [DEPTH-1:0][4:0]       o_addr
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_count;
    logic [DEPTH-1:0]       r_vld;
    logic [DEPTH-1:0][4:0]  r_addr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            r_addr  <= '0;
        end else begin
            if (i_push) begin
                r_addr[r_wptr] <= i_push_addr;
                r_vld[r_wptr]  <= 1'b1;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    // The entry being popped no longer counts as pending; its data commits next cycle via bypass.
    assign o_vld      = r_vld & ~(DEPTH'(i_pop) << r_rptr);
    assign o_addr     = r_addr;
    assign o_pop_addr = r_addr[r_rptr];
    assign o_count    = r_count;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write port owner merging ALU results with in-order load responses.
// Define WB_SCOREBOARD_EN for per-address hazard compare; otherwise any pending load marks sources busy.
module wb_arbiter import wb_pkg::*; #(parameter int LD_DEPTH = wb_pkg::LD_DEPTH) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(LD_DEPTH) + 1;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_sel;
    logic [4:0]                w_pop_addr;
    logic [CW-1:0]             w_count;
    logic [LD_DEPTH-1:0]       w_vld;
    logic [LD_DEPTH-1:0][4:0]  w_addrs;
    logic                      w_hit1;
    logic                      w_hit2;
    wb_req_t                   w_req;
    wb_req_t                   r_req;
    logic                      r_wren;
    wb_ld_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (bus.ld_issue_rd),
        .i_pop       (w_pop),
        .o_pop_addr  (w_pop_addr),
        .o_count     (w_count),
        .o_vld       (w_vld),
        .o_addr      (w_addrs)
    );
    assign bus.ld_issue_ready = w_count < CW'(LD_DEPTH);
    assign bus.ld_resp_ready  = !bus.alu_valid && w_count != '0;
    assign bus.ld_pending     = w_count;
    assign w_push = bus.ld_issue && bus.ld_issue_ready;
    assign w_pop  = bus.ld_resp_valid && bus.ld_resp_ready;
    assign w_sel  = bus.alu_valid || w_pop;
    assign w_req  = bus.alu_valid ? wb_req_t'{bus.alu_rd_addr, bus.alu_rd_data}
                                  : wb_req_t'{w_pop_addr, bus.ld_resp_data};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wren <= 1'b0;
            r_req  <= '0;
        end else begin
            r_wren <= w_sel && w_req.addr != 5'd0;
            if (w_sel)
                r_req <= w_req;
        end
    end
    assign bus.rd_wren = r_wren;
    assign bus.rd_addr = r_req.addr;
    assign bus.rd_data = r_req.data;
`ifdef WB_SCOREBOARD_EN
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            w_hit1 = w_hit1 | (w_vld[i] && w_addrs[i] == bus.rs1_addr);
            w_hit2 = w_hit2 | (w_vld[i] && w_addrs[i] == bus.rs2_addr);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{w_vld, w_addrs};
    assign w_hit1   = w_count != '0;
    assign w_hit2   = w_count != '0;
`endif
    assign bus.rs1_busy = bus.rs1_addr != 5'd0 && w_hit1;
    assign bus.rs2_busy = bus.rs2_addr != 5'd0 && w_hit2;
    a_issue_when_full: assert property (@(posedge clk) disable iff (rst) !(bus.ld_issue && !bus.ld_issue_ready));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for the writeback arbiter.
module tb_wb_arbiter;
    import wb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    wb_arbiter_if bus ();
    wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    task automatic check_wr(input string tag, input logic wren, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_wren"}, 32'(bus.rd_wren), 32'(wren));
        check({tag, "_addr"}, 32'(bus.rd_addr), 32'(a));
        check({tag, "_data"}, bus.rd_data, d);
    endtask
    task automatic issue(input logic [4:0] a);
        bus.ld_issue    = 1'b1;
        bus.ld_issue_rd = a;
        tick();
        bus.ld_issue = 1'b0;
    endtask
    initial begin
        bus.alu_valid     = 1'b0;
        bus.alu_rd_addr   = '0;
        bus.alu_rd_data   = '0;
        bus.ld_issue      = 1'b0;
        bus.ld_issue_rd   = '0;
        bus.ld_resp_valid = 1'b0;
        bus.ld_resp_data  = '0;
        bus.rs1_addr      = 5'd9;
        bus.rs2_addr      = 5'd10;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check_wr("reset", 1'b0, 5'd0, 32'h0);
        check("reset_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
        check("reset_resp_ready", 32'(bus.ld_resp_ready), 32'd0);
        check("reset_pending", 32'(bus.ld_pending), 32'd0);
        check("reset_busy", 32'({bus.rs1_busy, bus.rs2_busy}), 32'd0);
        // ALU writes: one-cycle latency, x0 suppressed
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd5;
        bus.alu_rd_data = 32'hDEADBEEF;
        tick();
        check_wr("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
        bus.alu_rd_addr = 5'd0;
        bus.alu_rd_data = 32'h1;
        tick();
        check("alu0_wren", 32'(bus.rd_wren), 32'd0);
        bus.alu_valid = 1'b0;
        tick();
        check("idle_wren", 32'(bus.rd_wren), 32'd0);
        // two loads, in-order responses
        issue(5'd3);
        check("ld_pend1", 32'(bus.ld_pending), 32'd1);
        issue(5'd7);
        check("ld_pend2", 32'(bus.ld_pending), 32'd2);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h11;
        settle();
        check("ld_resp_ready", 32'(bus.ld_resp_ready), 32'd1);
        tick();
        check_wr("ld_x3", 1'b1, 5'd3, 32'h11);
        check("ld_pend3", 32'(bus.ld_pending), 32'd1);
        bus.ld_resp_data = 32'h22;
        tick();
        bus.ld_resp_valid = 1'b0;
        check_wr("ld_x7", 1'b1, 5'd7, 32'h22);
        check("ld_pend4", 32'(bus.ld_pending), 32'd0);
        check("ld_resp_ready_empty", 32'(bus.ld_resp_ready), 32'd0);
        // ALU priority stalls a waiting response
        issue(5'd4);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h44;
        bus.alu_valid     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_rd_addr = 5'(10 + i);
            bus.alu_rd_data = 32'h100 + 32'(i);
            settle();
            check("stall_resp_ready", 32'(bus.ld_resp_ready), 32'd0);
            tick();
            check_wr("stall_alu", 1'b1, 5'(10 + i), 32'h100 + 32'(i));
            check("stall_pend", 32'(bus.ld_pending), 32'd1);
        end
        bus.alu_valid = 1'b0;
        settle();
        check("unstall_resp_ready", 32'(bus.ld_resp_ready), 32'd1);
        tick();
        bus.ld_resp_valid = 1'b0;
        check_wr("stall_x4", 1'b1, 5'd4, 32'h44);
        check("stall_pend0", 32'(bus.ld_pending), 32'd0);
        // fill the queue, then pop+push in one cycle and wrap the pointers
        for (int i = 1; i <= 4; i++) issue(5'(i));
        check("full_pend", 32'(bus.ld_pending), 32'd4);
        check("full_issue_ready", 32'(bus.ld_issue_ready), 32'd0);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'hA1;
        tick();
        check_wr("full_x1", 1'b1, 5'd1, 32'hA1);
        check("full_pend3", 32'(bus.ld_pending), 32'd3);
        check("full_issue_ready3", 32'(bus.ld_issue_ready), 32'd1);
        bus.ld_resp_data = 32'hA2;
        issue(5'd5);
        check_wr("pushpop_x2", 1'b1, 5'd2, 32'hA2);
        check("pushpop_pend", 32'(bus.ld_pending), 32'd3);
        for (int i = 3; i <= 5; i++) begin
            bus.ld_resp_data = 32'hA0 + 32'(i);
            tick();
            check_wr("drain", 1'b1, 5'(i), 32'hA0 + 32'(i));
        end
        bus.ld_resp_valid = 1'b0;
        check("drain_pend", 32'(bus.ld_pending), 32'd0);
        // scoreboard
        issue(5'd9);
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd10;
        settle();
        check("sb_rs1_busy", 32'(bus.rs1_busy), 32'd1);
        check("sb_rs2_busy", 32'(bus.rs2_busy), 32'(!SB));
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h99;
        settle();
        check("sb_rs1_resp_cycle", 32'(bus.rs1_busy), 32'(!SB));
        tick();
        bus.ld_resp_valid = 1'b0;
        settle();
        check("sb_rs_clear", 32'({bus.rs1_busy, bus.rs2_busy}), 32'd0);
        check_wr("sb_x9", 1'b1, 5'd9, 32'h99);
        issue(5'd0);
        bus.rs1_addr = 5'd0;
        settle();
        check("x0_pend", 32'(bus.ld_pending), 32'd1);
        check("x0_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        check("x0_rs2_busy", 32'(bus.rs2_busy), 32'(!SB));
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'hF0;
        tick();
        bus.ld_resp_valid = 1'b0;
        check("x0_wren", 32'(bus.rd_wren), 32'd0);
        check("x0_pend0", 32'(bus.ld_pending), 32'd0);
        // reset with loads outstanding
        bus.rs1_addr = 5'd2;
        issue(5'd1);
        issue(5'd2);
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd20;
        bus.alu_rd_data = 32'h5;
        issue(5'd3);
        bus.alu_valid = 1'b0;
        check("pre_rst_pend", 32'(bus.ld_pending), 32'd3);
        check("pre_rst_busy", 32'(bus.rs1_busy), 32'd1);
        check("pre_rst_wren", 32'(bus.rd_wren), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst_pend", 32'(bus.ld_pending), 32'd0);
        check("rst_busy", 32'({bus.rs1_busy, bus.rs2_busy}), 32'd0);
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
        issue(5'd6);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h66;
        tick();
        bus.ld_resp_valid = 1'b0;
        check_wr("post_rst_x6", 1'b1, 5'd6, 32'h66);
        check("post_rst_pend", 32'(bus.ld_pending), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
